// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, reset PC, FSM encoding
// and the buffered {pc, instr} entry.
package fetch_unit_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Two-entry {pc, instr} buffer between fetch and decode; flush empties it in one edge.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            // Push into a full buffer is only legal alongside a pop, so the slot being
            // overwritten is the head that leaves this edge.
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, 2-entry decode buffer, redirect
// handling with response drop and misaligned-target flag.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        align_err_out
);

    logic [1:0]   state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic         drop_q;
    logic         align_q;
    logic         rvalid_own;
    logic         push, pop;
    logic [1:0]   fifo_count;
    logic [1:0]   occ_after;
    fetch_entry_t head;
    logic         req_in_flight;

    // A response owed to a request abandoned by reset is swallowed before any
    // response is attributed to the current request.
    assign rvalid_own = imem_rvalid_in & ~drop_q;
    assign pop        = instr_valid_out & instr_ready_in & ~branch_taken_in;
    assign push       = (state == S_WAIT) & rvalid_own & ~branch_taken_in;
    assign occ_after  = fifo_count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        case (state)
            S_REQ:     state_nxt = branch_taken_in ? S_DISCARD : S_WAIT;
            S_WAIT: begin
                if (branch_taken_in)
                    state_nxt = rvalid_own ? S_REQ : S_DISCARD;
                else if (rvalid_own) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    state_nxt    = (occ_after <= 2'd1) ? S_REQ : S_HOLD;
                end
            end
            S_DISCARD: if (rvalid_own) state_nxt = S_REQ;
            S_HOLD:    if (pop || branch_taken_in) state_nxt = S_REQ;
            default:   state_nxt = S_REQ;
        endcase
        if (branch_taken_in)
            fetch_pc_nxt = word_align(branch_target_in);
    end

    assign req_in_flight = (state == S_WAIT) || (state == S_DISCARD);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            align_q  <= 1'b0;
            drop_q   <= (req_in_flight && !rvalid_own) || (drop_q && !imem_rvalid_in);
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            align_q  <= branch_taken_in & (|branch_target_in[1:0]);
            drop_q   <= drop_q & ~imem_rvalid_in;
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (push),
        .push_data ({fetch_pc, imem_rdata_in}),
        .pop       (pop),
        .flush     (branch_taken_in),
        .head      (head),
        .count     (fifo_count)
    );

    assign imem_req_out    = (state == S_REQ) & ~rst_in;
    assign imem_addr_out   = fetch_pc;
    assign instr_valid_out = (fifo_count != 2'd0);
    assign instr_out       = head.instr;
    assign pc_out          = head.pc;
    assign align_err_out   = align_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory, queue-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        branch_taken_in = 1'b0;
    logic [31:0] branch_target_in = '0;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_rvalid_in = 1'b0;
    logic [31:0] imem_rdata_in = '0;
    logic        instr_valid_out;
    logic        instr_ready_in = 1'b1;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        align_err_out;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_rvalid_in   (imem_rvalid_in),
        .imem_rdata_in    (imem_rdata_in),
        .instr_valid_out  (instr_valid_out),
        .instr_ready_in   (instr_ready_in),
        .instr_out        (instr_out),
        .pc_out           (pc_out),
        .align_err_out    (align_err_out)
    );

    always #5 clk_in = ~clk_in;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_at(input string nm, input logic [31:0] q[$], input int idx,
                          input logic [31:0] exp);
        if (idx >= q.size()) begin
            compared++;
            mismatched++;
            $display("FAIL %s: entry %0d absent (have %0d) expected %h", nm, idx, q.size(), exp);
        end else
            chk(nm, q[idx], exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
    endfunction

    // ---------------- memory model ----------------
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];
    int    lat  = 1;
    int    mcyc = 0;

    always @(posedge clk_in) begin
        mcyc++;
        #1;
        if (pend.size() != 0 && pend[0].due <= mcyc) begin
            imem_rvalid_in = 1'b1;
            imem_rdata_in  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid_in = 1'b0;
            imem_rdata_in  = 32'hBAD0_BAD0;
        end
    end

    always @(negedge clk_in)
        if (imem_req_out === 1'b1) pend.push_back('{imem_addr_out, mcyc + lat});

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_fp    = RST_PC;
    bit          m_out   = 0;   // own request awaiting response
    bit          m_taint = 0;   // that response must be discarded
    bit          m_drop  = 0;   // response of a request abandoned by reset
    bit          m_align = 0;
    bit          rst_prev = 0;
    logic [31:0] reqs[$];
    logic [31:0] rq_cyc[$];
    logic [31:0] pops[$];
    int          cyc = 0;

    always @(negedge clk_in) begin
        bit exp_req, pop;
        cyc++;
        if (rst_in) begin
            if (rst_prev) begin
                chk("rst_req",   imem_req_out, 0);
                chk("rst_valid", instr_valid_out, 0);
                chk("rst_align", align_err_out, 0);
                chk("rst_instr", instr_out, 0);
                chk("rst_pc",    pc_out, 0);
            end
            if (imem_rvalid_in) begin
                if (m_drop) m_drop = 0;
                else        m_out  = 0;
            end
            if (m_out) m_drop = 1;
            m_out = 0; m_taint = 0; m_align = 0;
            mq.delete();
            m_fp = RST_PC;
        end else begin
            exp_req = !m_out && mq.size() <= 1;
            chk("req", imem_req_out, exp_req);
            if (exp_req) begin
                chk("req_addr", imem_addr_out, m_fp);
                reqs.push_back(m_fp);
                rq_cyc.push_back(cyc);
            end
            chk("valid", instr_valid_out, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("pc_out", pc_out, mq[0].pc);
                chk("instr_out", instr_out, mq[0].instr);
            end
            chk("align_err", align_err_out, m_align);

            pop = mq.size() != 0 && instr_ready_in && !branch_taken_in;
            if (pop) begin
                pops.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (imem_rvalid_in) begin
                if (m_drop) m_drop = 0;
                else begin
                    if (!m_taint && !branch_taken_in) begin
                        mq.push_back('{m_fp, imem_rdata_in});
                        m_fp = m_fp + 32'd4;
                    end
                    m_out = 0; m_taint = 0;
                end
            end
            if (exp_req) begin
                m_out = 1; m_taint = branch_taken_in;
            end
            if (branch_taken_in) begin
                m_fp = branch_target_in & ~32'h3;
                mq.delete();
                if (m_out) m_taint = 1;
                m_align = |branch_target_in[1:0];
            end else
                m_align = 0;
        end
        rst_prev = rst_in;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic do_reset(input bit rdy);
        rst_in = 1'b1; branch_taken_in = 1'b0; instr_ready_in = rdy;
        repeat (3) step();
        rst_in = 1'b0;
        reqs.delete(); rq_cyc.delete(); pops.delete();
    endtask

    task automatic wait_req(input int n);
        for (int i = 0; i < 50 && reqs.size() < n; i++) step();
        chk("wait_req", reqs.size(), n);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        branch_taken_in = 1'b1; branch_target_in = tgt;
        step();
        branch_taken_in = 1'b0;
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'hB2E4;

        // Streaming after reset, 1-cycle memory
        lat = 1; do_reset(1);
        repeat (8) step();
        chk_at("t1_req0", reqs, 0, 32'h0);
        chk_at("t1_req1", reqs, 1, 32'h4);
        chk_at("t1_req2", reqs, 2, 32'h8);
        if (rq_cyc.size() >= 3) begin
            chk("t1_gap01", rq_cyc[1] - rq_cyc[0], 2);
            chk("t1_gap12", rq_cyc[2] - rq_cyc[1], 2);
        end else chk("t1_reqcnt", rq_cyc.size(), 3);
        chk_at("t1_pc0", pops, 0, 32'h0);
        chk_at("t1_pc1", pops, 1, 32'h4);
        chk_at("t1_pc2", pops, 2, 32'h8);

        // Decode stalled: buffer fills to two, fetch holds
        lat = 1; do_reset(0);
        repeat (10) step();
        chk("t2_reqcnt", reqs.size(), 2);
        chk("t2_nopop", pops.size(), 0);
        chk("t2_valid", instr_valid_out, 1);
        instr_ready_in = 1'b1;
        repeat (6) step();
        chk_at("t2_pc0", pops, 0, 32'h0);
        chk_at("t2_pc1", pops, 1, 32'h4);
        chk_at("t2_req2", reqs, 2, 32'h8);

        // Redirect while waiting on a slow response
        lat = 3; do_reset(1);
        wait_req(1);
        redirect(32'h100);
        repeat (12) step();
        chk_at("t3_req1", reqs, 1, 32'h100);
        chk_at("t3_pc0", pops, 0, 32'h100);

        // Redirect in the same cycle as the response
        lat = 1; do_reset(1);
        wait_req(1);
        redirect(32'h200);
        chk("t4_empty", instr_valid_out, 0);
        step();
        chk_at("t4_req1", reqs, 1, 32'h200);
        if (rq_cyc.size() >= 2) chk("t4_gap", rq_cyc[1] - rq_cyc[0], 2);
        repeat (4) step();
        chk_at("t4_pc0", pops, 0, 32'h200);

        // Misaligned target
        lat = 1; do_reset(1);
        wait_req(1);
        redirect(32'h102);
        chk("t5_align_hi", align_err_out, 1);
        step();
        chk("t5_align_lo", align_err_out, 0);
        chk_at("t5_req1", reqs, 1, 32'h100);

        // Address wrap
        lat = 1; do_reset(1);
        wait_req(1);
        redirect(32'hFFFF_FFFC);
        repeat (6) step();
        chk_at("t6_req1", reqs, 1, 32'hFFFF_FFFC);
        chk_at("t6_req2", reqs, 2, 32'h0);
        chk_at("t6_pc0", pops, 0, 32'hFFFF_FFFC);
        chk_at("t6_pc1", pops, 1, 32'h0);

        // Reset while a request is in flight: its late response must be ignored
        lat = 3; do_reset(1);
        wait_req(1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        reqs.delete(); rq_cyc.delete(); pops.delete();
        repeat (12) step();
        chk_at("t7_req0", reqs, 0, RST_PC);
        chk_at("t7_req1", reqs, 1, RST_PC + 32'd4);
        chk_at("t7_pc0", pops, 0, RST_PC);

        // Ragged ready pattern with a mid-stream redirect
        lat = 2; do_reset(1);
        for (int i = 0; i < 40; i++) begin
            instr_ready_in = pat[i % 16];
            if (i == 17) begin
                branch_taken_in = 1'b1; branch_target_in = 32'h340;
            end else
                branch_taken_in = 1'b0;
            step();
        end
        branch_taken_in = 1'b0; instr_ready_in = 1'b1;
        repeat (10) step();
        chk_at("t8_pc0", pops, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
